// File: rtl/uart_wb_pkg.sv
// Shared constants and FSM state type for the UART-to-Wishbone debug bridge.
package uart_wb_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ST_OK     = 8'h2B;
    localparam logic [7:0] ST_ERR    = 8'h21;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_ADDR = 3'd1,
        CMD_DATA = 3'd2,
        BUS      = 3'd3,
        TX       = 3'd4
    } state_t;

endpackage

// File: rtl/uart_wb_bridge.sv
// Serial debug bridge: 'W'/'R' command frames from the uart become single
// 32-bit Wishbone cycles, answered with a status byte (plus read data).
module uart_wb_bridge
    import uart_wb_pkg::*;
#(
    parameter int idle_timeout = 1000000,
    parameter int bus_timeout  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    localparam int IW = $clog2(idle_timeout + 1);
    localparam int BW = $clog2(bus_timeout + 1);

    // Handshakes: a rx byte is taken on the edge that raises rx_ack (rx_avail=1,
    // rx_ack=0); tx_wr is a one-cycle strobe issued only after tx_busy was seen
    // low, with tx_busy ignored for the cycle after each strobe.
    state_t          state;
    logic [1:0]      byte_cnt;
    logic            is_read;
    logic [IW-1:0]   idle_cnt;
    logic [BW-1:0]   bus_cnt;
    logic [39:0]     resp;
    logic [2:0]      tx_idx;
    logic            tx_guard;
    logic            consume;

    assign consume = rx_avail && !rx_ack &&
                     (state == IDLE || state == CMD_ADDR || state == CMD_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rx_ack   <= 1'b0;
            tx_wr    <= 1'b0;
            tx_data  <= 8'h00;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            byte_cnt <= 2'd0;
            is_read  <= 1'b0;
            idle_cnt <= '0;
            bus_cnt  <= '0;
            resp     <= 40'h0;
            tx_idx   <= 3'd0;
            tx_guard <= 1'b0;
        end else begin
            rx_ack <= consume;
            tx_wr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (consume && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                        is_read  <= (rx_data == CMD_READ);
                        byte_cnt <= 2'd0;
                        idle_cnt <= '0;
                        state    <= CMD_ADDR;
                    end
                end
                CMD_ADDR, CMD_DATA: begin
                    if (consume) begin
                        idle_cnt <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == CMD_ADDR)
                            wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        else
                            wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        if (byte_cnt == 2'd3) begin
                            if (state == CMD_ADDR && !is_read) begin
                                state <= CMD_DATA;
                            end else begin
                                state    <= BUS;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_sel_o <= 4'hF;
                                wb_we_o  <= !is_read;
                                bus_cnt  <= '0;
                            end
                        end
                    end else if (idle_cnt == IW'(idle_timeout - 1)) begin
                        state <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                BUS: begin
                    // Ack is checked first so an ack on the expiry cycle still succeeds.
                    if (wb_ack_i || bus_cnt == BW'(bus_timeout - 1)) begin
                        resp     <= wb_ack_i ? {ST_OK, (is_read ? wb_dat_i : 32'h0)}
                                             : {ST_ERR, 32'h0};
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        wb_we_o  <= 1'b0;
                        tx_idx   <= 3'd0;
                        tx_guard <= 1'b0;
                        state    <= TX;
                    end else begin
                        bus_cnt <= bus_cnt + 1'b1;
                    end
                end
                TX: begin
                    if (tx_wr) begin
                        tx_guard <= 1'b1;
                        resp     <= {resp[31:0], 8'h00};
                        if (tx_idx == (is_read ? 3'd4 : 3'd0))
                            state <= IDLE;
                        else
                            tx_idx <= tx_idx + 3'd1;
                    end else if (tx_guard) begin
                        tx_guard <= 1'b0;
                    end else if (!tx_busy) begin
                        tx_wr   <= 1'b1;
                        tx_data <= resp[39:32];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: uart rx/tx models, Wishbone slave model, frame
// table plus random frames scored against a frame-level reference model.
module tb_uart_wb_bridge;

    localparam int IDLE_TO = 64;
    localparam int BUS_TO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

    always #5 clk = ~clk;

    uart_wb_bridge #(.idle_timeout(IDLE_TO), .bus_timeout(BUS_TO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          len;
    } bus_t;

    typedef struct {
        int          dly;
        logic [31:0] rdata;
    } cfg_t;

    typedef struct {
        bit          rd;
        logic [31:0] adr;
        logic [31:0] dat;
        int          dly;
        logic [31:0] rdata;
        logic [7:0]  exp_st;
        logic [31:0] exp_word;
        int          exp_len;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    bus_t       exp_bus_q[$];
    bus_t       obs_bus_q[$];
    cfg_t       cfg_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart receive side: byte presented until rx_ack has been seen for it.
    initial begin
        rx_avail = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rx_ack && rx_q.size() > 0) rx_q.delete(0);
            rx_avail = (rx_q.size() != 0);
            rx_data  = rx_avail ? rx_q[0] : 8'h00;
        end
    end

    // uart transmit side: busy for 2..5 cycles after a strobe, reported one cycle late.
    initial begin
        int left;
        bit int_prev, prev_wr, int_now;
        left = 0; int_prev = 0; prev_wr = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            int_now = (left > 0);
            if (tx_wr) begin
                chk("tx_wr_while_busy", int_now, 0);
                chk("tx_wr_width", prev_wr, 0);
                chk("tx_wr_during_cyc", wb_cyc_o, 0);
                obs_q.push_back(tx_data);
            end
            prev_wr = tx_wr;
            if (left > 0) left--;
            if (tx_wr) left = $urandom_range(2, 5);
            tx_busy  = int_prev;
            int_prev = int_now;
        end
    end

    // Wishbone slave: acks in cycle index cfg.dly of the bus phase (-1 never).
    initial begin
        bit   in_cyc;
        int   k;
        cfg_t cur;
        bus_t rec;
        in_cyc = 0; k = 0;
        cur.dly = -1; cur.rdata = 32'h0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'hA5A5_5A5A;
        forever begin
            @(negedge clk);
            if (wb_cyc_o) begin
                if (!in_cyc) begin
                    in_cyc = 1; k = 0;
                    if (cfg_q.size() > 0) cur = cfg_q.pop_front();
                    else begin cur.dly = -1; cur.rdata = 32'h0; end
                    rec.adr = wb_adr_o; rec.dat = wb_dat_o; rec.we = wb_we_o;
                    chk("wb_sel", wb_sel_o, 4'hF);
                    chk("wb_stb", wb_stb_o, 1);
                end else begin
                    k++;
                end
                wb_ack_i = (k == cur.dly);
                wb_dat_i = (k == cur.dly) ? cur.rdata : 32'hA5A5_5A5A;
            end else begin
                if (in_cyc) begin
                    in_cyc  = 0;
                    rec.len = k + 1;
                    obs_bus_q.push_back(rec);
                end
                wb_ack_i = 1'b0;
                wb_dat_i = 32'hA5A5_5A5A;
            end
        end
    end

    // Frame-level reference: slave acking in bus-phase cycle dly succeeds when
    // dly falls inside the bus_timeout window, otherwise the phase lasts BUS_TO.
    function automatic void ref_model(input bit rd, input int dly, input logic [31:0] rdata,
                                      output logic [7:0] st, output logic [31:0] word,
                                      output int len);
        bit ok;
        ok   = (dly >= 0) && (dly < BUS_TO);
        st   = ok ? 8'h2B : 8'h21;
        word = (ok && rd) ? rdata : 32'h0;
        len  = ok ? dly + 1 : BUS_TO;
    endfunction

    task automatic queue_frame(input bit rd, input logic [31:0] adr, input logic [31:0] dat,
                               input int dly, input logic [31:0] rdata, input logic [7:0] st,
                               input logic [31:0] word, input int len);
        bus_t b;
        cfg_t c;
        rx_q.push_back(rd ? 8'h52 : 8'h57);
        for (int i = 3; i >= 0; i--) rx_q.push_back(adr[8*i +: 8]);
        if (!rd) for (int i = 3; i >= 0; i--) rx_q.push_back(dat[8*i +: 8]);
        c.dly = dly; c.rdata = rdata;
        cfg_q.push_back(c);
        b.adr = adr; b.dat = rd ? 32'h0 : dat; b.we = !rd; b.len = len;
        exp_bus_q.push_back(b);
        exp_q.push_back(st);
        if (rd) for (int i = 3; i >= 0; i--) exp_q.push_back(word[8*i +: 8]);
    endtask

    task automatic clear_all();
        exp_q.delete(); obs_q.delete();
        exp_bus_q.delete(); obs_bus_q.delete();
        cfg_q.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((obs_q.size() < exp_q.size() || obs_bus_q.size() < exp_bus_q.size()
                || rx_q.size() != 0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_bound"}, n < 6000, 1);
        repeat (12) @(negedge clk);
        chk({tag, "_tx_count"}, obs_q.size(), exp_q.size());
        chk({tag, "_bus_count"}, obs_bus_q.size(), exp_bus_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_tx_byte"}, obs_q[i], exp_q[i]);
        for (int i = 0; i < exp_bus_q.size() && i < obs_bus_q.size(); i++) begin
            chk({tag, "_adr"}, obs_bus_q[i].adr, exp_bus_q[i].adr);
            chk({tag, "_we"}, obs_bus_q[i].we, exp_bus_q[i].we);
            chk({tag, "_len"}, obs_bus_q[i].len, exp_bus_q[i].len);
            if (exp_bus_q[i].we) chk({tag, "_dat"}, obs_bus_q[i].dat, exp_bus_q[i].dat);
        end
        clear_all();
    endtask

    initial begin
        vec_t        vecs[6];
        logic [7:0]  st;
        logic [31:0] word;
        int          len, n, dly;
        bit          rd;
        logic [31:0] adr, dat, rdata;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rx_ack", rx_ack, 0);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        reset = 1'b0;

        vecs[0] = '{0, 32'h0000_1000, 32'hDEAD_BEEF, 2,  32'h0,         8'h2B, 32'h0,         3};
        vecs[1] = '{1, 32'h0000_1000, 32'h0,         1,  32'h1234_5678, 8'h2B, 32'h1234_5678, 2};
        vecs[2] = '{1, 32'h0000_2000, 32'h0,         -1, 32'h0,         8'h21, 32'h0,         16};
        vecs[3] = '{1, 32'h0000_3000, 32'h0,         15, 32'hCAFE_F00D, 8'h2B, 32'hCAFE_F00D, 16};
        vecs[4] = '{1, 32'h0000_4000, 32'h0,         0,  32'h0BAD_F00D, 8'h2B, 32'h0BAD_F00D, 1};
        vecs[5] = '{0, 32'hFFFF_FFFC, 32'h0102_0304, 16, 32'h0,         8'h21, 32'h0,         16};
        for (int i = 0; i < 6; i++) begin
            queue_frame(vecs[i].rd, vecs[i].adr, vecs[i].dat, vecs[i].dly, vecs[i].rdata,
                        vecs[i].exp_st, vecs[i].exp_word, vecs[i].exp_len);
            drain($sformatf("vec%0d", i));
        end

        // Stray byte in IDLE is swallowed silently before a valid write.
        rx_q.push_back(8'h41);
        queue_frame(0, 32'h4, 32'h1, 1, 32'h0, 8'h2B, 32'h0, 2);
        drain("stray");

        // Partial write abandoned by the idle timeout, then a normal read.
        rx_q.push_back(8'h57); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        repeat (3 * IDLE_TO) @(negedge clk);
        queue_frame(1, 32'h8, 32'h0, 3, 32'h89AB_CDEF, 8'h2B, 32'h89AB_CDEF, 4);
        drain("idle_to");

        // Two frames queued together: the second waits out the first's BUS/TX.
        queue_frame(1, 32'h10, 32'h0, 4, 32'h5555_AAAA, 8'h2B, 32'h5555_AAAA, 5);
        queue_frame(0, 32'h14, 32'h7777_0001, 0, 32'h0, 8'h2B, 32'h0, 1);
        drain("b2b");

        // Reset while a bus cycle is open: cycle dropped, no response.
        queue_frame(1, 32'h20, 32'h0, -1, 32'h0, 8'h21, 32'h0, 16);
        n = 0;
        while (!wb_cyc_o && n < 200) begin @(negedge clk); n++; end
        chk("rst_mid_cyc_seen", wb_cyc_o, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_cyc", wb_cyc_o, 0);
        chk("rst_mid_stb", wb_stb_o, 0);
        chk("rst_mid_sel", wb_sel_o, 0);
        repeat (60) @(negedge clk);
        chk("rst_mid_no_tx", obs_q.size(), 0);
        clear_all();
        queue_frame(0, 32'h24, 32'hAAAA_0000, 2, 32'h0, 8'h2B, 32'h0, 3);
        drain("after_rst");

        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(1, 3);
            for (int f = 0; f < n; f++) begin
                rd    = $urandom_range(0, 1);
                adr   = $urandom;
                dat   = $urandom;
                rdata = $urandom;
                dly   = $urandom_range(0, 22);
                if (dly > 20) dly = -1;
                ref_model(rd, dly, rdata, st, word, len);
                queue_frame(rd, adr, dat, dly, rdata, st, word, len);
            end
            drain($sformatf("rand%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_wb_bridge.md
# uart_wb_bridge

Debug bridge that turns a byte-oriented command stream from the SoC `uart` module into single 32-bit Wishbone master cycles. It lets a host on the serial line read and write any bus address without CPU involvement. It sits between the `uart` rx/tx handshake ports and a Wishbone arbiter master port, and has the same shape as `lm32d`.

## Interface
Parameters:
- `idle_timeout`, default 1000000: clock cycles allowed between bytes of one command before the frame is discarded.
- `bus_timeout`, default 256: clock cycles allowed for `wb_ack_i` before the bus cycle is aborted.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `rx_data`  in  8  received byte from `uart`
- `rx_avail`  in  1  byte pending in `uart`
- `rx_ack`  out  1  one-cycle consume pulse to `uart`
- `tx_data`  out  8  byte to transmit
- `tx_wr`  out  1  one-cycle transmit strobe
- `tx_busy`  in  1  `uart` transmitter busy
- `wb_adr_o`  out  32  byte address
- `wb_dat_o`  out  32  write data
- `wb_dat_i`  in  32  read data
- `wb_sel_o`  out  4  byte lanes; always 4'hF during a cycle
- `wb_we_o`  out  1  write enable
- `wb_cyc_o`, `wb_stb_o`  out  1 each  cycle and strobe; always equal
- `wb_ack_i`  in  1  slave acknowledge

## Operation
- Frames:
  - Write: 0x57 ('W'), then 4 address bytes, then 4 data bytes.
  - Read: 0x52 ('R'), then 4 address bytes.
  - Multi-byte fields are sent MSB first.
- Responses:
  - Every frame is answered with one status byte: 0x2B ('+') if the slave acked, 0x21 ('!') on bus timeout.
  - A read frame additionally returns 4 data bytes, MSB first. On a bus timeout these bytes are 0x00.
- In IDLE, any byte other than 0x57 or 0x52 is consumed and dropped. No response is sent.
- States and transitions:
  - IDLE to CMD_ADDR on a valid command byte.
  - CMD_ADDR (byte count 0..3) to CMD_DATA after the 4th address byte of a write, or to BUS after the 4th address byte of a read.
  - CMD_DATA (byte count 0..3) to BUS after the 4th data byte.
  - BUS to TX after ack or bus timeout.
  - TX (index 0..4) to IDLE after the last response byte.
- Byte consume rule: `rx_ack` pulses for one cycle when `rx_avail`=1 and `rx_ack`=0, and only in IDLE, CMD_ADDR or CMD_DATA.
- Bytes that arrive during BUS or TX are not acked. They remain pending in `uart` and are consumed after the return to IDLE.
- Address and data are assembled by left-shift: `reg <= {reg[23:0], rx_data}`.
- Idle timeout:
  - The counter restarts on each consumed byte.
  - If it reaches `idle_timeout` while in CMD_ADDR or CMD_DATA, the FSM returns to IDLE silently and the partial frame is lost.

## Timing
- Reset values: `rx_ack`=0, `tx_wr`=0, `tx_data`=0, `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0, `wb_sel_o`=0, `wb_adr_o`=0, `wb_dat_o`=0, state IDLE.
- Reset asserted mid-cycle drops `wb_cyc_o`/`wb_stb_o` on the next edge, regardless of `wb_ack_i`.
- Bus cycle start: `wb_cyc_o`/`wb_stb_o` assert on the cycle after the last byte of the frame is consumed.
  - They deassert on the edge where `wb_ack_i`=1 is sampled. Read data is latched on that same edge.
  - An ack arriving in the first cycle with cyc high gives a 1-cycle bus phase.
- Bus timeout: the bus counter starts at 0 when cyc rises. If `wb_ack_i` has not been seen after `bus_timeout` cycles, cyc/stb drop and status becomes 0x21.
- An ack arriving in the same cycle the timeout expires counts as success.
- Transmit handshake:
  - `tx_wr` pulses for exactly one cycle, only while `tx_busy`=0. `tx_data` is valid in that cycle.
  - After each pulse, the FSM ignores `tx_busy` for one cycle, because `uart` asserts busy one cycle late. It then waits for `tx_busy`=0 before the next byte.
- The first response byte goes out no earlier than 1 cycle after the bus phase ends.

## Structure
- Package `uart_wb_pkg` holds:
  - command constants CMD_WRITE=8'h57 and CMD_READ=8'h52;
  - status constants ST_OK=8'h2B and ST_ERR=8'h21;
  - the FSM state enum (IDLE, CMD_ADDR, CMD_DATA, BUS, TX).
- No sub-module. The two timeout counters and the byte index live inline.
- The bridge instantiates no `uart`; the SoC top connects one.

## Test plan
- Write frame 57 00 00 10 00 DE AD BE EF with the slave acking after 2 cycles -> one bus cycle with adr=0x00001000, dat_o=0xDEADBEEF, we=1, sel=F; then tx byte 2B.
- Read frame 52 00 00 10 00 with the slave returning 0x12345678 -> we=0 at adr 0x1000; tx bytes 2B 12 34 56 78 in order, each `tx_wr` one cycle wide.
- Read to an address whose slave never acks, with `bus_timeout`=16 -> cyc drops after 16 cycles; tx bytes 21 00 00 00 00.
- Stray byte 41 followed by write frame 57 00 00 00 04 00 00 00 01 -> 41 acked and ignored; the write to 0x4 executes and 2B is returned.
- Send 57 00 00, then stall longer than `idle_timeout`, then send a read frame 52 00 00 00 08 -> partial write discarded with no bus cycle; the read executes at 0x8 normally.
- Assert `reset` for 1 cycle while cyc is high -> cyc/stb are 0 on the next edge, FSM is in IDLE, and no response byte is sent.
